// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - control codes, target/state enums and decode helpers for mem_stage_ctrl
package mem_stage_pkg;

    localparam logic [6:0] CTRL_NOP  = 7'b0000000;
    localparam logic [6:0] CTRL_KRD0 = 7'b1100010;
    localparam logic [6:0] CTRL_KRD1 = 7'b1101010;
    localparam logic [6:0] CTRL_PRD  = 7'b1001110;
    localparam logic [6:0] CTRL_RWR  = 7'b0100001;

    typedef enum logic [1:0] {TGT_KERNEL, TGT_PIXEL, TGT_PICTURE} tgt_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    function automatic logic ctrl_is_access(input logic [6:0] c);
        return (c == CTRL_KRD0) || (c == CTRL_KRD1) || (c == CTRL_PRD) || (c == CTRL_RWR);
    endfunction

    function automatic tgt_e ctrl_target(input logic [6:0] c);
        if (c == CTRL_PRD) return TGT_PIXEL;
        if (c == CTRL_RWR) return TGT_PICTURE;
        return TGT_KERNEL;
    endfunction

endpackage

// File: rtl/mem_perf_counters.sv
// rtl/mem_perf_counters.sv - wrapping access and stall counters for mem_stage_ctrl
module mem_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc_k,
    input  logic        i_inc_p,
    input  logic        i_inc_r,
    input  logic        i_stall,
    output logic [31:0] o_k,
    output logic [31:0] o_p,
    output logic [31:0] o_r,
    output logic [31:0] o_stall
);

    logic [31:0] r_k, r_p, r_r, r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k     <= '0;
            r_p     <= '0;
            r_r     <= '0;
            r_stall <= '0;
        end else begin
            if (i_inc_k) r_k <= r_k + 32'd1;
            if (i_inc_p) r_p <= r_p + 32'd1;
            if (i_inc_r) r_r <= r_r + 32'd1;
            if (i_stall) r_stall <= r_stall + 32'd1;
        end
    end

    assign o_k     = r_k;
    assign o_p     = r_p;
    assign o_r     = r_r;
    assign o_stall = r_stall;

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - M-stage req/ack sequencer for kernel memory, pixel ROM and picture RAM
// Optional counter bank enabled by MEM_STAGE_PERF_CNT_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int KAW            = 10,
    parameter int PAW            = 16,
    parameter int RAW            = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidM,
    input  logic [6:0]      CtrlM,
    input  logic [31:0]     AddrM,
    input  logic [31:0]     WriteDataM,
    output logic            StallMem,
    output logic [31:0]     ReadDataM,
    output logic            ReadValidM,
    output logic            ErrM,
    output logic            KReq,
    output logic            KBank,
    output logic [KAW-1:0]  KAddr,
    input  logic [31:0]     KData,
    input  logic            KAck,
    output logic            PReq,
    output logic [PAW-1:0]  PAddr,
    input  logic [31:0]     PData,
    input  logic            PAck,
    output logic            RReq,
    output logic            RWe,
    output logic [RAW-1:0]  RAddr,
    output logic [31:0]     RWData,
    input  logic            RAck,
    output logic [31:0]     PerfK,
    output logic [31:0]     PerfP,
    output logic [31:0]     PerfR,
    output logic [31:0]     PerfStall
);

    localparam int AW = (KAW > PAW) ? ((KAW > RAW) ? KAW : RAW) : ((PAW > RAW) ? PAW : RAW);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    state_e          r_state, w_state_nxt;
    tgt_e            r_tgt;
    logic            r_bank;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_timeout;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_ack;
    logic            w_expire;
    logic [31:0]     w_rdata;
    logic            w_unused_addr;

    assign w_unused_addr = ^{AddrM[31:AW+2], AddrM[1:0]};

    assign w_accept = (r_state == S_IDLE) && ValidM && ctrl_is_access(CtrlM);
    assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_ack   = 1'b0;
        w_rdata = '0;
        case (r_tgt)
            TGT_KERNEL:  begin w_ack = KAck; w_rdata = KData; end
            TGT_PIXEL:   begin w_ack = PAck; w_rdata = PData; end
            TGT_PICTURE: begin w_ack = RAck; w_rdata = '0;    end
            default:     begin w_ack = 1'b0; w_rdata = '0;    end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        StallMem    = 1'b0;
        ReadValidM  = 1'b0;
        ErrM        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    StallMem    = 1'b1;
                end else if (ValidM && (CtrlM != CTRL_NOP)) begin
                    ErrM = 1'b1;
                end
            end
            S_WAIT: begin
                StallMem = 1'b1;
                if (w_ack || w_expire) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ReadValidM  = !r_timeout && (r_tgt != TGT_PICTURE);
                ErrM        = r_timeout;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tgt     <= TGT_KERNEL;
            r_bank    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tgt     <= ctrl_target(CtrlM);
                r_bank    <= CtrlM[3];
                r_addr    <= AddrM[AW+1:2];
                r_wdata   <= WriteDataM;
                r_timeout <= 1'b0;
                r_cnt     <= '0;
            end else if (r_state == S_WAIT) begin
                // An ack on the final counted cycle still wins over the timeout.
                if (w_ack) begin
                    r_rdata <= w_rdata;
                end else if (w_expire) begin
                    r_rdata   <= '0;
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign KReq   = (r_state == S_WAIT) && (r_tgt == TGT_KERNEL);
    assign PReq   = (r_state == S_WAIT) && (r_tgt == TGT_PIXEL);
    assign RReq   = (r_state == S_WAIT) && (r_tgt == TGT_PICTURE);
    assign RWe    = RReq;
    assign KBank  = r_bank;
    assign KAddr  = r_addr[KAW-1:0];
    assign PAddr  = r_addr[PAW-1:0];
    assign RAddr  = r_addr[RAW-1:0];
    assign RWData = r_wdata;
    assign ReadDataM = r_rdata;

`ifdef MEM_STAGE_PERF_CNT_EN
    logic w_done_ok;
    assign w_done_ok = (r_state == S_DONE) && !r_timeout;

    mem_perf_counters u_perf (
        .clk     (clk),
        .reset   (reset),
        .i_inc_k (w_done_ok && (r_tgt == TGT_KERNEL)),
        .i_inc_p (w_done_ok && (r_tgt == TGT_PIXEL)),
        .i_inc_r (w_done_ok && (r_tgt == TGT_PICTURE)),
        .i_stall (StallMem),
        .o_k     (PerfK),
        .o_p     (PerfP),
        .o_r     (PerfR),
        .o_stall (PerfStall)
    );
`else
    assign PerfK     = '0;
    assign PerfP     = '0;
    assign PerfR     = '0;
    assign PerfStall = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl with randomized accesses
module tb_mem_stage_ctrl;

    localparam int KAW = 10;
    localparam int PAW = 16;
    localparam int RAW = 16;
    localparam int T   = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           ValidM;
    logic [6:0]     CtrlM;
    logic [31:0]    AddrM, WriteDataM;
    logic           StallMem, ReadValidM, ErrM;
    logic [31:0]    ReadDataM;
    logic           KReq, KBank, KAck, PReq, PAck, RReq, RWe, RAck;
    logic [KAW-1:0] KAddr;
    logic [PAW-1:0] PAddr;
    logic [RAW-1:0] RAddr;
    logic [31:0]    KData, PData, RWData;
    logic [31:0]    PerfK, PerfP, PerfR, PerfStall;

    mem_stage_ctrl #(.KAW(KAW), .PAW(PAW), .RAW(RAW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .ValidM(ValidM), .CtrlM(CtrlM), .AddrM(AddrM),
        .WriteDataM(WriteDataM), .StallMem(StallMem), .ReadDataM(ReadDataM),
        .ReadValidM(ReadValidM), .ErrM(ErrM), .KReq(KReq), .KBank(KBank), .KAddr(KAddr),
        .KData(KData), .KAck(KAck), .PReq(PReq), .PAddr(PAddr), .PData(PData), .PAck(PAck),
        .RReq(RReq), .RWe(RWe), .RAddr(RAddr), .RWData(RWData), .RAck(RAck),
        .PerfK(PerfK), .PerfP(PerfP), .PerfR(PerfR), .PerfStall(PerfStall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   k_ex = 0, p_ex = 0, r_ex = 0, stall_ex = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (!reset && (ReadValidM || ErrM)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp rv=%b err=%b required none", ReadValidM, ErrM);
            end else begin
                m_e = exp_q.pop_front();
                if (ReadValidM === m_e.is_err || ErrM !== m_e.is_err ||
                    (m_e.chk_data && ReadDataM !== m_e.data)) begin
                    failures++;
                    $display("FAIL resp rv=%b err=%b data=%h required err=%b data=%h",
                             ReadValidM, ErrM, ReadDataM, m_e.is_err, m_e.data);
                end
            end
        end
    end

    // One instruction through M: lat is the Req cycle (1-based) in which the target acks.
    task automatic do_op(input logic v, input logic [6:0] c, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input bit spur);
        int  tgt;
        int  req_cycles;
        int  stalls;
        bit  tmo;
        bit  bad;
        bit  exp_req;
        tgt = -1;
        if (v) begin
            case (c)
                7'b1100010, 7'b1101010: tgt = 0;
                7'b1001110:             tgt = 1;
                7'b0100001:             tgt = 2;
                default:                tgt = -1;
            endcase
        end
        bad        = v && (c != 7'd0) && (tgt < 0);
        tmo        = (tgt >= 0) && (lat > T);
        req_cycles = (tgt < 0) ? 0 : (tmo ? T : lat);
        if (bad) exp_q.push_back('{1'b1, 1'b0, 32'h0});
        else if (tgt >= 0 && tmo) exp_q.push_back('{1'b1, 1'b1, 32'h0});
        else if (tgt == 0 || tgt == 1) exp_q.push_back('{1'b0, 1'b1, rd});
        if (!tmo) begin
            if (tgt == 0) k_ex++;
            if (tgt == 1) p_ex++;
            if (tgt == 2) r_ex++;
        end
        if (tgt >= 0) stall_ex += 1 + req_cycles;

        @(posedge clk); #1;
        ValidM = v; CtrlM = c; AddrM = a; WriteDataM = wd;
        stalls = 0;
        for (int ci = 0; ci < 64; ci++) begin
            KAck  = (tgt == 0) ? (ci == lat) : (spur && $urandom_range(0, 1) == 1);
            PAck  = (tgt == 1) ? (ci == lat) : (spur && $urandom_range(0, 1) == 1);
            RAck  = (tgt == 2) ? (ci == lat) : (spur && $urandom_range(0, 1) == 1);
            KData = (tgt == 0 && ci == lat) ? rd : $urandom();
            PData = (tgt == 1 && ci == lat) ? rd : $urandom();
            @(negedge clk);
            exp_req = (tgt >= 0) && (ci >= 1) && (ci <= req_cycles);
            chk1("kreq", KReq, exp_req && tgt == 0);
            chk1("preq", PReq, exp_req && tgt == 1);
            chk1("rreq", RReq, exp_req && tgt == 2);
            if (exp_req && tgt == 0) begin
                chk("kaddr", 32'(KAddr), (a >> 2) & ((32'd1 << KAW) - 1));
                chk1("kbank", KBank, c == 7'b1101010);
            end
            if (exp_req && tgt == 1) chk("paddr", 32'(PAddr), (a >> 2) & ((32'd1 << PAW) - 1));
            if (exp_req && tgt == 2) begin
                chk("raddr", 32'(RAddr), (a >> 2) & ((32'd1 << RAW) - 1));
                chk("rwdata", RWData, wd);
                chk1("rwe", RWe, 1'b1);
            end
            if (!StallMem) begin
                if (tgt == 2) chk("wr_rdata", ReadDataM, 32'h0);
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", stalls, (tgt >= 0) ? 1 + req_cycles : 0);
    endtask

    initial begin
        int          op, lat;
        logic [6:0]  c;
        reset = 1'b1; ValidM = 1'b0; CtrlM = '0; AddrM = '0; WriteDataM = '0;
        KAck = 1'b0; PAck = 1'b0; RAck = 1'b0; KData = '0; PData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("rst_stall", StallMem, 1'b0);
        chk1("rst_kreq", KReq, 1'b0);
        chk1("rst_preq", PReq, 1'b0);
        chk1("rst_rreq", RReq, 1'b0);
        chk1("rst_rvalid", ReadValidM, 1'b0);
        chk1("rst_err", ErrM, 1'b0);
        chk("rst_rdata", ReadDataM, 32'h0);

        do_op(1'b1, 7'b1001110, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        do_op(1'b1, 7'b1101010, 32'h0000_000C, 32'h0, 5, 32'h1234_5678, 1'b0);
        do_op(1'b1, 7'b0100001, 32'h0000_0020, 32'h0000_00FF, 2, 32'h0, 1'b0);
        do_op(1'b1, 7'b1001110, 32'h0000_0040, 32'h0, 100, 32'h0, 1'b0);
        do_op(1'b1, 7'b1111111, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b1);
        do_op(1'b1, 7'b1001110, 32'h0000_0044, 32'h0, 4, 32'hCAFE_F00D, 1'b1);
        do_op(1'b1, 7'b1100010, 32'hFFFF_FFFC, 32'h0, T, 32'hA5A5_5A5A, 1'b1);
        do_op(1'b1, 7'b1100010, 32'h0000_0100, 32'h0, T + 1, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 7);
            lat = $urandom_range(1, T + 2);
            case (op)
                0: c = 7'b1100010;
                1: c = 7'b1101010;
                2, 7: c = 7'b1001110;
                3: c = 7'b0100001;
                4: begin
                    c = 7'($urandom_range(1, 127));
                    while (c == 7'b1100010 || c == 7'b1101010 || c == 7'b1001110 || c == 7'b0100001)
                        c = 7'($urandom_range(1, 127));
                end
                default: c = 7'd0;
            endcase
            if (op == 6) do_op(1'b0, 7'b1001110, $urandom(), $urandom(), lat, $urandom(), 1'b1);
            else do_op(1'b1, c, $urandom(), $urandom(), lat, $urandom(), $urandom_range(0, 1) == 1);
        end

        @(posedge clk); #1;
        ValidM = 1'b0; CtrlM = '0; KAck = 1'b0; PAck = 1'b0; RAck = 1'b0;
        @(negedge clk);
`ifdef MEM_STAGE_PERF_CNT_EN
        chk("perf_k", PerfK, k_ex);
        chk("perf_p", PerfP, p_ex);
        chk("perf_r", PerfR, r_ex);
        chk("perf_stall", PerfStall, stall_ex);
`else
        chk("perf_k", PerfK, 32'h0);
        chk("perf_p", PerfP, 32'h0);
        chk("perf_r", PerfR, 32'h0);
        chk("perf_stall", PerfStall, 32'h0);
`endif
        chk("exp_q_empty", exp_q.size(), 0);

        // Make ReadDataM non-zero so the reset clear is visible.
        do_op(1'b1, 7'b1001110, 32'h0000_0080, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
        @(posedge clk); #1;
        ValidM = 1'b1; CtrlM = 7'b1100010; AddrM = 32'h0000_0204; KAck = 1'b0; PAck = 1'b0; RAck = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mid_wait_kreq", KReq, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; ValidM = 1'b0; CtrlM = '0;
        @(posedge clk); #1;
        reset = 1'b0; KAck = 1'b1; KData = 32'h7777_7777;
        @(negedge clk);
        chk1("rstw_stall", StallMem, 1'b0);
        chk1("rstw_kreq", KReq, 1'b0);
        chk1("rstw_preq", PReq, 1'b0);
        chk1("rstw_rreq", RReq, 1'b0);
        chk1("rstw_rvalid", ReadValidM, 1'b0);
        chk1("rstw_err", ErrM, 1'b0);
        chk("rstw_rdata", ReadDataM, 32'h0);
        chk("rstw_perf_k", PerfK, 32'h0);
        chk("rstw_perf_stall", PerfStall, 32'h0);
        @(posedge clk); #1;
        KAck = 1'b0;
        @(negedge clk);
        chk1("late_ack_rvalid", ReadValidM, 1'b0);
        chk("late_ack_rdata", ReadDataM, 32'h0);
        chk("exp_q_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller sitting directly downstream of the instruction decoder. It consumes the 7-bit memory-control word (Ctrl) after it has been piped to the M stage and sequences multi-cycle req/ack accesses to the kernel memory, pixel ROM and picture RAM. It stalls the pipeline while an access is outstanding and returns read data to writeback.

Parameters:
KAW, 10, kernel memory word-address width
PAW, 16, pixel ROM word-address width
RAW, 16, picture RAM word-address width
TIMEOUT_CYCLES, 64, WAIT cycles without ack before aborting (≥2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ValidM  in  1  M-stage instruction valid
CtrlM  in  7  memory-control word from decoder, piped to M
AddrM  in  32  byte address (ALU result)
WriteDataM  in  32  store data
StallMem  out  1  freeze IF..M pipeline registers
ReadDataM  out  32  read result; valid when ReadValidM=1
ReadValidM  out  1  one-cycle completion strobe for reads
ErrM  out  1  one-cycle error strobe (bad code or timeout)
KReq  out  1  kernel memory request
KBank  out  1  kernel bank select (CtrlM[3])
KAddr  out  KAW  kernel word address
KData  in  32  kernel read data
KAck  in  1  kernel ack; KData valid same cycle
PReq  out  1  pixel ROM request
PAddr  out  PAW  ROM word address
PData  in  32  ROM read data
PAck  in  1  ROM ack
RReq  out  1  picture RAM request
RWe  out  1  RAM write enable (always 1 with RReq)
RAddr  out  RAW  RAM word address
RWData  out  32  RAM write data
RAck  in  1  RAM ack

Behaviour:
- Recognised CtrlM codes: 7'b1100010 kernel read bank 0; 7'b1101010 kernel read bank 1; 7'b1001110 pixel read; 7'b0100001 picture write; 7'b0000000 no memory op.
- Word address = AddrM[W+1:2], truncated to the target width. AddrM[1:0] is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If ValidM and the code is recognised and non-zero: latch target, bank, address and data; go to WAIT.
  - StallMem = 1 combinationally in this accept cycle.
- WAIT:
  - The selected Req (with its address, bank and data) is held high from the cycle after acceptance until the ack is sampled.
  - StallMem = 1.
  - On the selected ack: capture read data (writes capture 0); go to DONE; Req drops on the same edge.
  - Acks from unselected targets are ignored.
- DONE (one cycle):
  - StallMem = 0.
  - ReadValidM = 1 for reads only; ReadDataM holds captured data until the next completion.
  - Return to IDLE.
- Minimum latency (ack in first Req cycle): 3 cycles accept→DONE, i.e. 2 stall cycles.
- Timeout:
  - A counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without ack: Req drops, ReadDataM = 0, ErrM = 1 in DONE, ReadValidM = 0.
- Unrecognised non-zero code with ValidM in IDLE: ErrM pulses 1 cycle, no stall, no request.
- ValidM = 0 or code 0: no action.
- CtrlM and AddrM are frozen by the stall; the controller uses only latched values after acceptance.
- At most one access is outstanding; only one Req is ever high.
- Reset (at any time, including mid-WAIT): state IDLE, all Req = 0, StallMem = 0, ReadValidM = 0, ErrM = 0, ReadDataM = 0, counter = 0. An ack arriving after reset is ignored.

Optional Feature:
- Macro MEM_STAGE_PERF_CNT_EN.
- Defined:
  - Adds four 32-bit wrapping counters: kernel reads, pixel reads, picture writes, total stall cycles.
  - Counters are cleared by reset and exposed on outputs PerfK, PerfP, PerfR, PerfStall.
  - Access counters increment in DONE only on non-timeout completion.
- Undefined: the same outputs exist, tied to 0, with no counter flops.

Decomposition:
- Package mem_stage_pkg:
  - The five CtrlM code localparams.
  - Target enum {TGT_KERNEL, TGT_PIXEL, TGT_PICTURE}.
  - State enum {S_IDLE, S_WAIT, S_DONE}.
- Sub-module mem_perf_counters: the counter bank, instantiated only under the macro.

Test Plan:
- Pixel read: CtrlM = 1001110, AddrM = 0x0000_0010, PAck one cycle after PReq, PData = 0xDEAD_BEEF → PAddr = 4, StallMem high 2 cycles, ReadValidM = 1 with ReadDataM = 0xDEAD_BEEF.
- Kernel bank 1: CtrlM = 1101010, AddrM = 0x0C → KBank = 1, KAddr = 3. Ack delayed 5 cycles → StallMem high 6 cycles, single ReadValidM.
- Picture write: CtrlM = 0100001, AddrM = 0x20, WriteDataM = 0x0000_00FF → RReq = RWe = 1, RAddr = 8, RWData = 0xFF. ReadValidM stays 0, ErrM stays 0.
- Timeout (TIMEOUT_CYCLES = 8): pixel read, PAck never asserted → PReq drops after 8 WAIT cycles, ErrM = 1, ReadDataM = 0, pipeline released.
- Bad code: CtrlM = 7'b1111111, ValidM = 1 → ErrM pulses 1 cycle, no Req, StallMem = 0. Also: a spurious KAck while a pixel read is in WAIT is ignored.
- Reset mid-WAIT: kernel read outstanding, reset high 1 cycle → all outputs at reset values. A late KAck produces no ReadValidM. With the macro defined, counters read 0.
